// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the RGB LED controller.
//   led_mode_t  : committed operating mode (HEARTBEAT, DIRECT, BREATHE, OFF)
//   ADDR_*      : register addresses seen on wr_addr
//   scale8()    : upper byte of an 8x8 unsigned product, i.e. (a*b)>>8
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    HEARTBEAT = 2'd0,
    DIRECT    = 2'd1,
    BREATHE   = 2'd2,
    OFF       = 2'd3
  } led_mode_t;

  localparam logic [1:0] ADDR_DUTY_R = 2'd0;
  localparam logic [1:0] ADDR_DUTY_G = 2'd1;
  localparam logic [1:0] ADDR_DUTY_B = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Full 16-bit product, upper 8 bits kept.
  function automatic logic [7:0] scale8(input logic [7:0] a, input logic [7:0] b);
    return 8'((16'(a) * 16'(b)) >> 8);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output stage: compares the shared PWM count against an effective
// duty and registers the active-low pin value.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (pin forced off = 1)
//   pwm_cnt  in  8-bit PWM phase counter
//   duty     in  effective duty (lit while pwm_cnt < duty)
//   force_on in  light the LED regardless of the comparison
//   led      out registered active-low LED pin
module pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty,
  input  logic       force_on,
  output logic       led
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b1;
    end else begin
      led <= ~(force_on | (pwm_cnt < duty));
    end
  end

endmodule

// File: rtl/rgb_led_controller.sv
// RGB LED controller: arbitrates the three active-low LEDs between a
// heartbeat, SoC-programmed PWM duties and a breathing sequencer. Register
// writes are staged in a single shadow slot and committed at the PWM period
// boundary so a period is never rendered with mixed settings.
// Optional build macro: LED_GAMMA_EN squares the effective duty ((d*d)>>8)
// after breathe scaling; when undefined the duty is linear.
// Ports:
//   sysClock   in  system clock
//   reset_n    in  asynchronous active-low reset
//   wr_valid   in  write request
//   wr_ready   out write can be accepted this cycle (slot empty)
//   wr_addr    in  0=DUTY_R 1=DUTY_G 2=DUTY_B 3=CTRL
//   wr_data    in  write data (CTRL: bits[1:0] = mode)
//   LED_R/G/B  out active-low LED pins
//   mode_o     out committed mode
//   pwm_sync   out one-cycle pulse after each PWM period boundary
module rgb_led_controller
  import led_ctrl_pkg::*;
#(
  parameter int PWM_PRESCALE        = 188,
  parameter int HEARTBEAT_BIT       = 23,
  parameter int BREATH_STEP_PERIODS = 4
) (
  input  logic       sysClock,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic [1:0] mode_o,
  output logic       pwm_sync
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int SW = (BREATH_STEP_PERIODS > 1) ? $clog2(BREATH_STEP_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(BREATH_STEP_PERIODS - 1);

  logic [PW-1:0]          presc_reg;
  logic [7:0]             pwm_cnt_reg;
  logic [HEARTBEAT_BIT:0] hb_reg;
  logic                   pwm_sync_reg;
  logic                   pend_valid_reg;
  logic [1:0]             pend_addr_reg;
  logic [7:0]             pend_data_reg;
  led_mode_t              mode_reg;
  logic [7:0]             level_reg;
  logic                   dir_down_reg;
  logic [SW-1:0]          step_reg;
  logic [2:0]             led_n;

  logic      tick;
  logic      boundary;
  logic      accept;
  logic      commit;
  led_mode_t new_mode;
  logic      enter_breathe;

  assign tick     = (presc_reg == PRESC_LAST);
  assign boundary = tick && (pwm_cnt_reg == 8'hFF);
  // Slot empty implies ready, so a commit and an accept never coincide; a
  // write taken in a boundary cycle therefore waits a full period.
  assign accept   = wr_valid && !pend_valid_reg;
  assign commit   = boundary && pend_valid_reg;
  assign new_mode = led_mode_t'(pend_data_reg[1:0]);
  // Only a real transition into BREATHE restarts the ramp.
  assign enter_breathe = commit && (pend_addr_reg == ADDR_CTRL) &&
                         (new_mode != mode_reg) && (new_mode == BREATHE);

  always_ff @(posedge sysClock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg    <= '0;
      pwm_cnt_reg  <= 8'd0;
      hb_reg       <= '0;
      pwm_sync_reg <= 1'b0;
    end else begin
      presc_reg    <= tick ? '0 : presc_reg + 1'b1;
      pwm_cnt_reg  <= tick ? pwm_cnt_reg + 8'd1 : pwm_cnt_reg;
      hb_reg       <= hb_reg + 1'b1;
      pwm_sync_reg <= boundary;
    end
  end

  always_ff @(posedge sysClock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= 2'd0;
      pend_data_reg  <= 8'd0;
    end else if (commit) begin
      pend_valid_reg <= 1'b0;
    end else if (accept) begin
      pend_valid_reg <= 1'b1;
      pend_addr_reg  <= wr_addr;
      pend_data_reg  <= wr_data;
    end
  end

  always_ff @(posedge sysClock or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg <= HEARTBEAT;
    end else if (commit && (pend_addr_reg == ADDR_CTRL)) begin
      mode_reg <= new_mode;
    end
  end

  // Breathing ramp: triangle 0..255..0, one step per BREATH_STEP_PERIODS
  // boundaries while in BREATHE; frozen otherwise.
  always_ff @(posedge sysClock or negedge reset_n) begin
    if (!reset_n) begin
      level_reg    <= 8'd0;
      dir_down_reg <= 1'b0;
      step_reg     <= '0;
    end else if (enter_breathe) begin
      level_reg    <= 8'd0;
      dir_down_reg <= 1'b0;
      step_reg     <= '0;
    end else if (boundary && (mode_reg == BREATHE)) begin
      if (step_reg == STEP_LAST) begin
        step_reg <= '0;
        if (!dir_down_reg) begin
          if (level_reg == 8'hFF) begin
            dir_down_reg <= 1'b1;
            level_reg    <= 8'hFE;
          end else begin
            level_reg <= level_reg + 8'd1;
          end
        end else begin
          if (level_reg == 8'd0) begin
            dir_down_reg <= 1'b0;
            level_reg    <= 8'd1;
          end else begin
            level_reg <= level_reg - 8'd1;
          end
        end
      end else begin
        step_reg <= step_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] duty_reg;
      logic [7:0] scaled;
      logic [7:0] eff;
      logic       force_on;

      always_ff @(posedge sysClock or negedge reset_n) begin
        if (!reset_n) begin
          duty_reg <= 8'd0;
        end else if (commit && (pend_addr_reg == 2'(gi))) begin
          duty_reg <= pend_data_reg;
        end
      end

      always_comb begin
        scaled = duty_reg;
        if (mode_reg == BREATHE) begin
          scaled = scale8(duty_reg, level_reg);
        end
`ifdef LED_GAMMA_EN
        eff = scale8(scaled, scaled);
`else
        eff = scaled;
`endif
        if ((mode_reg == HEARTBEAT) || (mode_reg == OFF)) begin
          eff = 8'd0;
        end
      end

      // Only the red channel carries the heartbeat.
      assign force_on = (gi == 0) && (mode_reg == HEARTBEAT) && hb_reg[HEARTBEAT_BIT];

      pwm_channel u_chan (
        .clk      (sysClock),
        .rst_n    (reset_n),
        .pwm_cnt  (pwm_cnt_reg),
        .duty     (eff),
        .force_on (force_on),
        .led      (led_n[gi])
      );
    end
  endgenerate

  assign LED_R    = led_n[0];
  assign LED_G    = led_n[1];
  assign LED_B    = led_n[2];
  assign wr_ready = ~pend_valid_reg;
  assign mode_o   = mode_reg;
  assign pwm_sync = pwm_sync_reg;

endmodule

// File: tb/tb_rgb_led_controller.sv
// Self-checking bench for rgb_led_controller with a cycle-level behavioural
// model (time since reset -> prescaler/PWM phase, triangle level from the
// number of breathe boundaries) plus hand-computed pin checks.
module tb_rgb_led_controller;

  localparam int P   = 2;
  localparam int HB  = 3;
  localparam int PER = P * 256;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic       LED_R, LED_G, LED_B;
  logic [1:0] mode_o;
  logic       pwm_sync;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  rgb_led_controller #(
    .PWM_PRESCALE        (P),
    .HEARTBEAT_BIT       (HB),
    .BREATH_STEP_PERIODS (1)
  ) dut (
    .sysClock (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .LED_R    (LED_R),
    .LED_G    (LED_G),
    .LED_B    (LED_B),
    .mode_o   (mode_o),
    .pwm_sync (pwm_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_n, m_mode, m_pv, m_pa, m_pd, m_bk;
  int m_duty [3];
  bit m_led [3];
  bit m_sync;

  function automatic int tri_lvl(input int k);
    int p;
    p = k % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic int eff_duty(input int d, input int mode, input int lev);
    int s;
    s = (mode == 2) ? (d * lev) / 256 : d;
`ifdef LED_GAMMA_EN
    s = (s * s) / 256;
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_n = 0; m_mode = 0; m_pv = 0; m_pa = 0; m_pd = 0; m_bk = 0; m_sync = 0;
    for (int c = 0; c < 3; c++) begin
      m_duty[c] = 0;
      m_led[c]  = 1;
    end
  endtask

  task automatic model_step();
    int  cnt, lev, nm;
    bit  bnd, lit;
    cnt = (m_n / P) % 256;
    bnd = ((m_n % PER) == PER - 1);
    lev = tri_lvl(m_bk);
    for (int c = 0; c < 3; c++) begin
      case (m_mode)
        0:       lit = (c == 0) && (((m_n >> HB) & 1) == 1);
        1, 2:    lit = cnt < eff_duty(m_duty[c], m_mode, lev);
        default: lit = 0;
      endcase
      m_led[c] = !lit;
    end
    m_sync = bnd;
    if (bnd && m_mode == 2) m_bk++;
    if (bnd && m_pv != 0) begin
      if (m_pa == 3) begin
        nm = m_pd & 3;
        if (nm != m_mode && nm == 2) m_bk = 0;
        m_mode = nm;
      end else begin
        m_duty[m_pa] = m_pd;
      end
      m_pv = 0;
    end else if (wr_valid && m_pv == 0) begin
      m_pv = 1;
      m_pa = int'(wr_addr);
      m_pd = int'(wr_data);
    end
    m_n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("led_r", LED_R, m_led[0]);
        chk("led_g", LED_G, m_led[1]);
        chk("led_b", LED_B, m_led[2]);
        chk("pwm_sync", pwm_sync, m_sync);
        chk("wr_ready", wr_ready, (m_pv == 0) ? 1 : 0);
        chk("mode_o", mode_o, m_mode);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic do_write(input int a, input int d);
    int k;
    wr_valid = 1'b1;
    wr_addr  = 2'(a);
    wr_data  = 8'(d);
    k = 0;
    while (wr_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      timeout("write_accept");
    end else begin
      @(negedge clk);
      $display("write addr=%0d data=%0d accepted t=%0t", a, d, $time);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_commit();
    int k;
    k = 0;
    while (wr_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) timeout("commit");
  endtask

  // Counts, over one full period, cycles each LED pin sits at level 0.
  task automatic count_period(output int r0, output int g0, output int b0);
    r0 = 0; g0 = 0; b0 = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (LED_R == 1'b0) r0++;
      if (LED_G == 1'b0) g0++;
      if (LED_B == 1'b0) b0++;
    end
  endtask

  task automatic run_len(output int len);
    logic v;
    v = LED_R;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (LED_R == v && len < 64);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0, g0, b0, len, k, a, d;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_led_r", LED_R, 1);
    chk("rst_led_g", LED_G, 1);
    chk("rst_led_b", LED_B, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_pwm_sync", pwm_sync, 0);
    chk("rst_mode", mode_o, 0);
    reset_n = 1'b1;

    // Heartbeat: red toggles every 2^HB cycles.
    run_len(len);
    for (int i = 0; i < 3; i++) begin
      run_len(len);
      chk("hb_run_len", len, 8);
    end
    k = 0;
    while (pwm_sync !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) timeout("first_sync");
    k = 0;
    do begin @(negedge clk); k++; end while (pwm_sync !== 1'b1 && k < 1000);
    chk("sync_period", k, PER);

    // DIRECT, red at 64/256.
    do_write(3, 1);
    do_write(0, 64);
    wait_commit();
    count_period(r0, g0, b0);
    chk("direct_r64_lit", r0, 128);
    chk("direct_g0_lit", g0, 0);

    // Duty boundaries: 0 never lit, 255 dark 1 count (P cycles).
    do_write(1, 0);
    do_write(2, 255);
    wait_commit();
    count_period(r0, g0, b0);
    chk("direct_r64_again", r0, 128);
    chk("duty0_dark", PER - g0, PER);
    chk("duty255_dark", PER - b0, 2);

    // Write presented in the boundary cycle waits a full period.
    k = 0;
    while ((m_n % PER) != PER - 1 && k < 2000) begin @(negedge clk); k++; end
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'd3;
    @(negedge clk);
    wr_valid = 1'b0;
    $display("write addr=3 data=3 presented in boundary cycle t=%0t", $time);
    chk("bnd_sync_now", pwm_sync, 1);
    chk("bnd_ready_low", wr_ready, 0);
    chk("bnd_mode_now", mode_o, 1);
    repeat (PER - 1) @(negedge clk);
    chk("bnd_mode_511", mode_o, 1);
    @(negedge clk);
    chk("bnd_mode_512", mode_o, 3);

    // BREATHE with red at 255: lit count tracks (255*level)>>8.
    do_write(0, 255);
    do_write(3, 2);
    wait_commit();
    for (int p = 0; p < 40; p++) begin
      count_period(r0, g0, b0);
      chk($sformatf("breathe_lit_p%0d", p), r0, 2 * ((255 * p) >> 8));
    end

    // Reset mid-period with a write pending.
    do_write(3, 1);
    repeat (8) @(negedge clk);
    chk("pre_rst_red_lit", LED_R, 0);
    chk("pre_rst_pending", wr_ready, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_led_r", LED_R, 1);
    chk("async_rst_led_g", LED_G, 1);
    chk("async_rst_led_b", LED_B, 1);
    chk("async_rst_mode", mode_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * PER) @(negedge clk);
    chk("post_rst_mode", mode_o, 0);

    // Randomized writes; the per-cycle compare does the checking.
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, 3));
      d = (a == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      do_write(a, d);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_commit();
    repeat (PER) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
